// File: rtl/nlp16af_pkg.sv
// -----------------------------------------------------------------------------
// nlp16af_pkg
//   Shared types for the NLP-16AF memory bus arbiter.
//   - arb_state_e : arbiter FSM states (IDLE -> BUSY -> ACK -> IDLE)
//   - grant_e     : which requester owns the memory port
//   - REQ_CORE / REQ_EXT : bit positions in the 2-bit request vector
//   - cnt_width() : wait-state counter width, never below 1 bit
// -----------------------------------------------------------------------------
package nlp16af_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_CORE = 1'b0,
    GNT_EXT  = 1'b1
  } grant_e;

  localparam int REQ_CORE = 0;
  localparam int REQ_EXT  = 1;

  // Counter must hold WAIT_CYCLES; a zero-wait build still gets one bit.
  function automatic int cnt_width(input int wait_cycles);
    if (wait_cycles < 1) begin
      return 1;
    end
    return $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr2.sv
// -----------------------------------------------------------------------------
// arb_rr2
//   Combinational 2-way round-robin picker.
//   Ports:
//     req[1:0]  in   request vector (bit REQ_CORE = core, bit REQ_EXT = external)
//     last      in   requester that owned the previous completed access
//     lock      in   external bus lock active (forces EXT while EXT requests)
//     valid     out  at least one request present
//     winner    out  selected requester (meaningful only when valid)
// -----------------------------------------------------------------------------
module arb_rr2
  import nlp16af_pkg::*;
(
  input  logic [1:0] req,
  input  grant_e     last,
  input  logic       lock,
  output logic       valid,
  output grant_e     winner
);

  always_comb begin
    valid  = |req;
    winner = GNT_CORE;
    if (lock && req[REQ_EXT]) begin
      winner = GNT_EXT;
    end else if (req[REQ_CORE] && req[REQ_EXT]) begin
      // Tie: the requester that did not own the last access goes next.
      winner = (last == GNT_CORE) ? GNT_EXT : GNT_CORE;
    end else if (req[REQ_EXT]) begin
      winner = GNT_EXT;
    end else begin
      winner = GNT_CORE;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares the single NLP-16AF memory port between the core bus unit and one
//   external requester (DMA/debug). Round-robin between the two, fixed
//   WAIT_CYCLES extra wait states, one outstanding access at a time.
//   Each access: IDLE (pick + latch) -> BUSY (WAIT_CYCLES+1 cycles, memory
//   strobe high) -> ACK (one-cycle ack to the winner) -> IDLE.
//
//   Parameters: WAIT_CYCLES (extra wait states, 0 allowed), AW, DW.
//   Ports:
//     i_clk, i_rst                      clock, synchronous active-high reset
//     i_core_req/we/addr/wdata          core request (held until o_core_ack)
//     o_core_ack, o_core_rdata          core completion pulse, read data (held)
//     i_ext_req/we/addr/wdata           external request
//     o_ext_ack, o_ext_rdata            external completion pulse, read data
//     i_ext_lock                        external bus lock (lock build only)
//     o_mem_en/we/addr/wdata            memory strobe and access fields
//     i_mem_rdata                       memory read data, taken in last BUSY cycle
//     o_err                             pulse: winner dropped its request early
//
//   Build option: define NLP16AF_ARB_LOCK_EN to add i_ext_lock and the
//   external lock flag; without it the arbiter is pure round-robin.
// -----------------------------------------------------------------------------
module mem_bus_arbiter
  import nlp16af_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int AW          = 16,
  parameter int DW          = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_core_req,
  input  logic          i_core_we,
  input  logic [AW-1:0] i_core_addr,
  input  logic [DW-1:0] i_core_wdata,
  output logic          o_core_ack,
  output logic [DW-1:0] o_core_rdata,
  input  logic          i_ext_req,
  input  logic          i_ext_we,
  input  logic [AW-1:0] i_ext_addr,
  input  logic [DW-1:0] i_ext_wdata,
  output logic          o_ext_ack,
  output logic [DW-1:0] o_ext_rdata,
`ifdef NLP16AF_ARB_LOCK_EN
  input  logic          i_ext_lock,
`endif
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_err
);

  localparam int                CNT_W    = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WAIT_CYCLES);

  arb_state_e      state_q, state_d;
  grant_e          grant_q, grant_d;
  grant_e          last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            err_seen_q, err_seen_d;
  logic [DW-1:0]   core_rdata_q, core_rdata_d;
  logic [DW-1:0]   ext_rdata_q, ext_rdata_d;

  // Access fields: only observed while BUSY, so they carry no reset.
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic            pick_valid;
  grant_e          pick_winner;
  logic            pick_lock;
  logic            win_req;

`ifdef NLP16AF_ARB_LOCK_EN
  logic            lock_q, lock_d;
  assign pick_lock = lock_q;
`else
  assign pick_lock = 1'b0;
`endif

  arb_rr2 u_rr2 (
    .req    ({i_ext_req, i_core_req}),
    .last   (last_grant_q),
    .lock   (pick_lock),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  assign win_req = (grant_q == GNT_EXT) ? i_ext_req : i_core_req;

  // ---- FSM: state register ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_valid) state_d = BUSY;
      BUSY:    if (cnt_q == '0) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_core_ack  = 1'b0;
    o_ext_ack   = 1'b0;
    o_err       = 1'b0;
    unique case (state_q)
      BUSY: begin
        o_mem_en    = 1'b1;
        o_mem_we    = we_q;
        o_mem_addr  = addr_q;
        o_mem_wdata = wdata_q;
        o_err       = !win_req && !err_seen_q;
      end
      ACK: begin
        o_core_ack = (grant_q == GNT_CORE);
        o_ext_ack  = (grant_q == GNT_EXT);
        o_err      = !win_req && !err_seen_q;
      end
      default: ;
    endcase
  end

  assign o_core_rdata = core_rdata_q;
  assign o_ext_rdata  = ext_rdata_q;

  // ---- Access bookkeeping: grant, wait counter, read capture, error ----
  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    err_seen_d   = err_seen_q;
    core_rdata_d = core_rdata_q;
    ext_rdata_d  = ext_rdata_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;

    unique case (state_q)
      IDLE: begin
        err_seen_d = 1'b0;
        if (pick_valid) begin
          grant_d = pick_winner;
          cnt_d   = CNT_LOAD;
          if (pick_winner == GNT_EXT) begin
            we_d    = i_ext_we;
            addr_d  = i_ext_addr;
            wdata_d = i_ext_wdata;
          end else begin
            we_d    = i_core_we;
            addr_d  = i_core_addr;
            wdata_d = i_core_wdata;
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!we_q) begin
          // Last BUSY cycle: read data lands in the owner's register so it
          // is already valid while the ack is high.
          if (grant_q == GNT_EXT) ext_rdata_d  = i_mem_rdata;
          else                    core_rdata_d = i_mem_rdata;
        end
        if (!win_req) err_seen_d = 1'b1;
      end
      ACK: begin
        last_grant_d = grant_q;
        if (!win_req) err_seen_d = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef NLP16AF_ARB_LOCK_EN
  always_comb begin
    lock_d = lock_q;
    if (state_q == ACK && grant_q == GNT_EXT) begin
      lock_d = i_ext_lock;
    end else if (state_q == IDLE && !i_ext_req) begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) lock_q <= 1'b0;
    else       lock_q <= lock_d;
  end
`endif

  // ---- Control and output-visible registers ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      grant_q      <= GNT_CORE;
      last_grant_q <= GNT_EXT;
      cnt_q        <= '0;
      err_seen_q   <= 1'b0;
      core_rdata_q <= '0;
      ext_rdata_q  <= '0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      err_seen_q   <= err_seen_d;
      core_rdata_q <= core_rdata_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

  // ---- Latched access fields ----
  always_ff @(posedge i_clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter with WAIT_CYCLES=2. The memory is a
//   fixed lookup (0x0100 -> 0xBEEF, otherwise addr ^ 0x5A5A).
//   The lock scenario runs only when NLP16AF_ARB_LOCK_EN is defined.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_core_req, i_core_we;
  logic [15:0] i_core_addr, i_core_wdata;
  logic        o_core_ack;
  logic [15:0] o_core_rdata;
  logic        i_ext_req, i_ext_we;
  logic [15:0] i_ext_addr, i_ext_wdata;
  logic        o_ext_ack;
  logic [15:0] o_ext_rdata;
`ifdef NLP16AF_ARB_LOCK_EN
  logic        i_ext_lock;
`endif
  logic        o_mem_en, o_mem_we;
  logic [15:0] o_mem_addr, o_mem_wdata;
  logic [15:0] i_mem_rdata;
  logic        o_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.WAIT_CYCLES(2), .AW(16), .DW(16)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_core_req   (i_core_req),
    .i_core_we    (i_core_we),
    .i_core_addr  (i_core_addr),
    .i_core_wdata (i_core_wdata),
    .o_core_ack   (o_core_ack),
    .o_core_rdata (o_core_rdata),
    .i_ext_req    (i_ext_req),
    .i_ext_we     (i_ext_we),
    .i_ext_addr   (i_ext_addr),
    .i_ext_wdata  (i_ext_wdata),
    .o_ext_ack    (o_ext_ack),
    .o_ext_rdata  (o_ext_rdata),
`ifdef NLP16AF_ARB_LOCK_EN
    .i_ext_lock   (i_ext_lock),
`endif
    .o_mem_en     (o_mem_en),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_rdata  (i_mem_rdata),
    .o_err        (o_err)
  );

  function automatic logic [15:0] mem_model(input logic [15:0] a);
    if (a == 16'h0100) return 16'hBEEF;
    return a ^ 16'h5A5A;
  endfunction

  assign i_mem_rdata = mem_model(o_mem_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advances until either ack (bounded to 20 cycles). side: 0 core, 1 ext, 2 timeout.
  task automatic wait_ack(output int side, output int lat, output int en_cnt,
                          output logic [15:0] addr, output logic we,
                          output logic [15:0] wd, output bit stable,
                          output int errs, output int both);
    bit seen;
    side = 2; lat = 0; en_cnt = 0; addr = '0; we = 1'b0; wd = '0;
    stable = 1'b1; errs = 0; both = 0; seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (o_err) errs++;
      if (o_mem_en) begin
        if (!seen) begin
          addr = o_mem_addr; we = o_mem_we; wd = o_mem_wdata; seen = 1'b1;
        end else if (addr !== o_mem_addr || we !== o_mem_we || wd !== o_mem_wdata) begin
          stable = 1'b0;
        end
        en_cnt++;
      end
      if (o_core_ack && o_ext_ack) both++;
      if (o_core_ack || o_ext_ack) begin
        side = o_ext_ack ? 1 : 0;
        lat  = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_core_req = 0; i_core_we = 0; i_core_addr = 0; i_core_wdata = 0;
    i_ext_req = 0;  i_ext_we = 0;  i_ext_addr = 0;  i_ext_wdata = 0;
`ifdef NLP16AF_ARB_LOCK_EN
    i_ext_lock = 0;
`endif
    tick(); tick();
    i_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int side, lat, en_cnt, errs, both, acks;
    logic [15:0] addr, wd;
    logic we;
    bit stable;
    logic [1:0] exp_seq [4];

    do_reset();
    check_eq("rst_mem_en", o_mem_en, 0);
    check_eq("rst_mem_addr", o_mem_addr, 0);
    check_eq("rst_core_ack", o_core_ack, 0);
    check_eq("rst_ext_ack", o_ext_ack, 0);
    check_eq("rst_core_rdata", o_core_rdata, 0);
    check_eq("rst_ext_rdata", o_ext_rdata, 0);
    check_eq("rst_err", o_err, 0);

    // 1: core read
    i_core_req = 1; i_core_we = 0; i_core_addr = 16'h0100;
    wait_ack(side, lat, en_cnt, addr, we, wd, stable, errs, both);
    check_eq("t1_side", side, 0);
    check_eq("t1_latency", lat, 4);
    check_eq("t1_en_cycles", en_cnt, 3);
    check_eq("t1_addr", addr, 16'h0100);
    check_eq("t1_we", we, 0);
    check_eq("t1_rdata", o_core_rdata, 16'hBEEF);
    check_eq("t1_err", errs, 0);
    tick();
    i_core_req = 0;
    check_eq("t1_rdata_held", o_core_rdata, 16'hBEEF);

    // 2: both request from reset
    do_reset();
    i_core_req = 1; i_core_addr = 16'h0200;
    i_ext_req  = 1; i_ext_we = 0; i_ext_addr = 16'h0300;
    wait_ack(side, lat, en_cnt, addr, we, wd, stable, errs, both);
    check_eq("t2_first_side", side, 0);
    check_eq("t2_first_lat", lat, 4);
    check_eq("t2_core_rdata", o_core_rdata, mem_model(16'h0200));
    tick();
    i_core_req = 0;
    wait_ack(side, lat, en_cnt, addr, we, wd, stable, errs, both);
    check_eq("t2_second_side", side, 1);
    check_eq("t2_ext_after_core", lat + 1, 5);
    check_eq("t2_ext_addr", addr, 16'h0300);
    check_eq("t2_ext_rdata", o_ext_rdata, mem_model(16'h0300));
    check_eq("t2_overlap", both, 0);
    check_eq("t2_err", errs, 0);
    tick();
    i_ext_req = 0;

    // 3: both held -> alternate C,E,C,E
    exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 0; exp_seq[3] = 1;
    i_core_req = 1; i_core_addr = 16'h0400;
    i_ext_req  = 1; i_ext_addr  = 16'h0500;
    for (int k = 0; k < 4; k++) begin
      wait_ack(side, lat, en_cnt, addr, we, wd, stable, errs, both);
      check_eq($sformatf("t3_side%0d", k), side, 32'(exp_seq[k]));
      check_eq($sformatf("t3_addr%0d", k), addr, exp_seq[k][0] ? 16'h0500 : 16'h0400);
      check_eq($sformatf("t3_err%0d", k), errs, 0);
    end
    tick();
    i_core_req = 0; i_ext_req = 0;

    // 4: ext write
    i_ext_req = 1; i_ext_we = 1; i_ext_addr = 16'h8000; i_ext_wdata = 16'h1234;
    wait_ack(side, lat, en_cnt, addr, we, wd, stable, errs, both);
    check_eq("t4_side", side, 1);
    check_eq("t4_we", we, 1);
    check_eq("t4_addr", addr, 16'h8000);
    check_eq("t4_wdata", wd, 16'h1234);
    check_eq("t4_stable", stable, 1);
    check_eq("t4_en_cycles", en_cnt, 3);
    check_eq("t4_ext_rdata_kept", o_ext_rdata, mem_model(16'h0500));
    tick();
    i_ext_req = 0; i_ext_we = 0;

    // 5a: core drops request mid-BUSY
    i_core_req = 1; i_core_we = 0; i_core_addr = 16'h0600;
    tick(); tick();
    i_core_req = 0;
    #1;
    check_eq("t5_err_pulse", o_err, 1);
    check_eq("t5_busy", o_mem_en, 1);
    wait_ack(side, lat, en_cnt, addr, we, wd, stable, errs, both);
    check_eq("t5_ack_side", side, 0);
    check_eq("t5_ack_lat", lat, 2);
    check_eq("t5_err_once", errs, 0);
    check_eq("t5_rdata", o_core_rdata, mem_model(16'h0600));
    tick();

    // 5b: reset in the middle of an access
    i_core_req = 1; i_core_addr = 16'h0700;
    tick(); tick();
    i_rst = 1;
    tick();
    check_eq("t5_rst_mem_en", o_mem_en, 0);
    check_eq("t5_rst_mem_addr", o_mem_addr, 0);
    check_eq("t5_rst_core_ack", o_core_ack, 0);
    check_eq("t5_rst_core_rdata", o_core_rdata, 0);
    check_eq("t5_rst_err", o_err, 0);
    i_rst = 0; i_core_req = 0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (o_core_ack || o_ext_ack) acks++;
    end
    check_eq("t5_no_ack_after_rst", acks, 0);

`ifdef NLP16AF_ARB_LOCK_EN
    // 6: external lock
    do_reset();
    i_ext_req = 1; i_ext_lock = 1; i_ext_addr = 16'h9000;
    wait_ack(side, lat, en_cnt, addr, we, wd, stable, errs, both);
    check_eq("t6_lock_first", side, 1);
    i_core_req = 1; i_core_addr = 16'h0A00;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) i_ext_lock = 0;
      wait_ack(side, lat, en_cnt, addr, we, wd, stable, errs, both);
      check_eq($sformatf("t6_locked_ext%0d", k), side, 1);
    end
    wait_ack(side, lat, en_cnt, addr, we, wd, stable, errs, both);
    check_eq("t6_core_after_unlock", side, 0);
    check_eq("t6_core_addr", addr, 16'h0A00);
    tick();
    i_core_req = 0; i_ext_req = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
